// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte/word data-memory responder for the
// MEMORY-stage load/store port. One request at a time over valid/ready, a
// fixed LATENCY to a one-cycle response pulse, little-endian byte lanes.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_byte_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  localparam int LANES   = DATA_WIDTH / 8;
  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;

  // Latched copy of the accepted request; the live inputs are ignored
  // once the block leaves IDLE.
  logic                  we_reg;
  logic                  byte_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  // Response side registers, all loaded on the edge that enters RESP.
  logic       resp_zero_reg;
  logic       resp_err_reg;
  logic       resp_byte_reg;
  logic [1:0] resp_lane_reg;

  logic                  ready_int;
  logic                  busy_int;
  logic                  resp_valid_int;
  logic                  accept;
  logic                  enter_resp;
  logic                  misaligned;
  logic [WORD_AW-1:0]    word_idx;
  logic [1:0]            lane_sel;
  logic [DATA_WIDTH-1:0] lane_rd_bus;

  // Address bits above the decoded range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

  assign accept     = (state_reg == IDLE) && req_valid_i;
  assign enter_resp = (state_reg == WAIT) && (count_reg == 4'd0);
  assign misaligned = !byte_reg && (addr_reg[1:0] != 2'b00);
  assign word_idx   = addr_reg[ADDR_WIDTH-1:2];
  assign lane_sel   = addr_reg[1:0];

  // State and latency counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state and handshake outputs. The acceptance edge always enters
  // WAIT with LATENCY-1 loaded, so RESP is entered exactly LATENCY edges
  // after acceptance for every legal LATENCY (including 1, where WAIT
  // lasts a single cycle).
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    ready_int      = 1'b0;
    busy_int       = 1'b0;
    resp_valid_int = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (req_valid_i) begin
          state_next = WAIT;
          count_next = LAT_M1;
        end
      end
      WAIT: begin
        busy_int = 1'b1;
        if (count_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP: begin
        busy_int       = 1'b1;
        resp_valid_int = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Capture the request on the acceptance edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      we_reg    <= req_we_i;
      byte_reg  <= req_byte_i;
      addr_reg  <= req_addr_i[ADDR_WIDTH-1:0];
      wdata_reg <= req_wdata_i;
    end
  end

  // Response qualifiers: stores and misaligned words return zero data;
  // the zero flag resets high so the data output reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_zero_reg <= 1'b1;
      resp_err_reg  <= 1'b0;
      resp_byte_reg <= 1'b0;
      resp_lane_reg <= 2'b00;
    end else if (enter_resp) begin
      resp_zero_reg <= we_reg || misaligned;
      resp_err_reg  <= misaligned;
      resp_byte_reg <= byte_reg;
      resp_lane_reg <= lane_sel;
    end
  end

  // One byte-wide RAM per lane; byte k of a word lives in lane k.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;
      logic       lane_hit;
      logic       lane_we;
      logic [7:0] lane_wbyte;

      assign lane_hit   = byte_reg ? (lane_sel == 2'(gi)) : 1'b1;
      assign lane_we    = enter_resp && we_reg && !misaligned && lane_hit;
      assign lane_wbyte = byte_reg ? wdata_reg[7:0] : wdata_reg[8*gi +: 8];

      // Lane write and registered read share the edge that enters RESP.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          lane_mem[word_idx] <= lane_wbyte;
        end
        if (enter_resp) begin
          lane_rd_reg <= lane_mem[word_idx];
        end
      end

      assign lane_rd_bus[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  // Load data is steered from the lane read registers: whole word, or the
  // addressed lane zero-extended for byte loads.
  always_comb begin
    resp_rdata_o = '0;
    if (!resp_zero_reg) begin
      if (resp_byte_reg) begin
        resp_rdata_o[7:0] = lane_rd_bus[8*resp_lane_reg +: 8];
      end else begin
        resp_rdata_o = lane_rd_bus;
      end
    end
  end

  assign req_ready_o  = ready_int;
  assign busy_o       = busy_int;
  assign resp_valid_o = resp_valid_int;
  assign resp_err_o   = resp_err_reg;

endmodule
